// File: rtl/wb_regfile_if.sv
// Write-back / decode bundle for the architectural register file.
// The pipeline drives it through the master side; the register file uses the slave side.
interface wb_regfile_if;
   logic        wb_commit;
   logic [31:0] wb_pc;
   logic [31:0] wb_inst;
   logic        wb_regwr;
   logic [4:0]  wb_rd;
   logic [31:0] wb_busw;
   logic        wb_csrwr;
   logic [1:0]  wb_csr_rd;
   logic [31:0] wb_csr_busw;
   logic        wb_trap;
   logic [31:0] wb_trap_pc;
   logic [31:0] wb_trap_cause;
   logic        wb_halt;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [1:0]  id_csr_rs;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_csr_data;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic        halted;
   logic [63:0] retire_cnt;
   logic [31:0] last_pc;
   logic [31:0] last_inst;

   modport master (
      output wb_commit, wb_pc, wb_inst, wb_regwr, wb_rd, wb_busw,
             wb_csrwr, wb_csr_rd, wb_csr_busw, wb_trap, wb_trap_pc, wb_trap_cause,
             wb_halt, id_rs1, id_rs2, id_csr_rs,
      input  id_rs1_data, id_rs2_data, id_csr_data, mtvec_o, mepc_o,
             halted, retire_cnt, last_pc, last_inst
   );

   modport slave (
      input  wb_commit, wb_pc, wb_inst, wb_regwr, wb_rd, wb_busw,
             wb_csrwr, wb_csr_rd, wb_csr_busw, wb_trap, wb_trap_pc, wb_trap_cause,
             wb_halt, id_rs1, id_rs2, id_csr_rs,
      output id_rs1_data, id_rs2_data, id_csr_data, mtvec_o, mepc_o,
             halted, retire_cnt, last_pc, last_inst
   );
endinterface

// File: rtl/wb_regfile.sv
// Architectural state: 31 GPRs, four machine CSRs, retirement counter and sticky halt.
// Reads are combinational with write-through bypass of the commit being retired this cycle.
module wb_regfile #(
   parameter logic [31:0] RST_MSTATUS = 32'h0000_1800,
   parameter logic [31:0] RST_MTVEC   = 32'h0000_0000
) (
   input logic         clk,
   input logic         rst_n,
   wb_regfile_if.slave bus
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e      state_q;
   logic [31:0] gpr_q [32];
   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mtvec_q,   mtvec_d;
   logic [31:0] mepc_q,    mepc_d;
   logic [31:0] mcause_q,  mcause_d;
   logic [63:0] retire_cnt_q;
   logic [31:0] last_pc_q;
   logic [31:0] last_inst_q;

   logic eff;
   logic gpr_we;
   logic csr_we;
   logic trap_we;

   assign eff     = bus.wb_commit && (state_q == StRun);
   assign gpr_we  = eff && bus.wb_regwr && (bus.wb_rd != 5'd0);
   assign csr_we  = eff && bus.wb_csrwr;
   assign trap_we = eff && bus.wb_trap;

   // Trap commit overrides a same-cycle CSR write to mepc/mcause only.
   always_comb begin
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;
      if (csr_we) begin
         unique case (bus.wb_csr_rd)
            2'd0: mstatus_d = bus.wb_csr_busw;
            2'd1: mtvec_d   = bus.wb_csr_busw;
            2'd2: mepc_d    = bus.wb_csr_busw;
            2'd3: mcause_d  = bus.wb_csr_busw;
         endcase
      end
      if (trap_we) begin
         mepc_d   = bus.wb_trap_pc;
         mcause_d = bus.wb_trap_cause;
      end
   end

   always_comb begin
      bus.id_rs1_data = gpr_q[bus.id_rs1];
      bus.id_rs2_data = gpr_q[bus.id_rs2];
      if (gpr_we && (bus.wb_rd == bus.id_rs1)) bus.id_rs1_data = bus.wb_busw;
      if (gpr_we && (bus.wb_rd == bus.id_rs2)) bus.id_rs2_data = bus.wb_busw;
      if (bus.id_rs1 == 5'd0) bus.id_rs1_data = 32'd0;
      if (bus.id_rs2 == 5'd0) bus.id_rs2_data = 32'd0;
   end

   // CSR reads see the value the next edge will store.
   always_comb begin
      bus.id_csr_data = mstatus_d;
      unique case (bus.id_csr_rs)
         2'd0: bus.id_csr_data = mstatus_d;
         2'd1: bus.id_csr_data = mtvec_d;
         2'd2: bus.id_csr_data = mepc_d;
         2'd3: bus.id_csr_data = mcause_d;
      endcase
   end

   assign bus.mtvec_o    = mtvec_d;
   assign bus.mepc_o     = mepc_d;
   assign bus.halted     = (state_q == StHalt);
   assign bus.retire_cnt = retire_cnt_q;
   assign bus.last_pc    = last_pc_q;
   assign bus.last_inst  = last_inst_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StRun;
         for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
         mstatus_q    <= RST_MSTATUS;
         mtvec_q      <= RST_MTVEC;
         mepc_q       <= 32'd0;
         mcause_q     <= 32'd0;
         retire_cnt_q <= 64'd0;
         last_pc_q    <= 32'd0;
         last_inst_q  <= 32'd0;
      end else begin
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
         if (gpr_we) gpr_q[bus.wb_rd] <= bus.wb_busw;
         if (eff) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
            last_pc_q    <= bus.wb_pc;
            last_inst_q  <= bus.wb_inst;
         end
         unique case (state_q)
            StRun:  if (eff && bus.wb_halt) state_q <= StHalt;
            StHalt: state_q <= StHalt;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expected values go through a scoreboard queue.
module tb_wb_regfile;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   logic [63:0] sb_val [$];
   string       sb_tag [$];
   logic [63:0] exp_cnt;

   wb_regfile_if bus ();

   wb_regfile #(
      .RST_MSTATUS(32'h0000_1800),
      .RST_MTVEC  (32'h0000_0100)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic sb_push(input string tag, input logic [63:0] val);
      sb_tag.push_back(tag);
      sb_val.push_back(val);
   endtask

   task automatic sb_check(input logic [63:0] obs);
      string       tag;
      logic [63:0] exp;
      tag = sb_tag.pop_front();
      exp = sb_val.pop_front();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      sb_push(tag, exp);
      sb_check(obs);
   endtask

   task automatic idle();
      bus.wb_commit     = 1'b0;
      bus.wb_pc         = 32'd0;
      bus.wb_inst       = 32'd0;
      bus.wb_regwr      = 1'b0;
      bus.wb_rd         = 5'd0;
      bus.wb_busw       = 32'd0;
      bus.wb_csrwr      = 1'b0;
      bus.wb_csr_rd     = 2'd0;
      bus.wb_csr_busw   = 32'd0;
      bus.wb_trap       = 1'b0;
      bus.wb_trap_pc    = 32'd0;
      bus.wb_trap_cause = 32'd0;
      bus.wb_halt       = 1'b0;
   endtask

   task automatic commit(input logic [31:0] pc, input logic [31:0] inst);
      bus.wb_commit = 1'b1;
      bus.wb_pc     = pc;
      bus.wb_inst   = inst;
   endtask

   // Let the edge happen, then move to the falling edge for the next drive.
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_cnt     = 64'd0;
      idle();
      bus.id_rs1    = 5'd0;
      bus.id_rs2    = 5'd0;
      bus.id_csr_rs = 2'd0;
      rst_n = 1'b0;
      #12;
      chk("rst_retire_cnt", bus.retire_cnt, 64'd0);
      chk("rst_halted",     64'(bus.halted), 64'd0);
      chk("rst_last_pc",    64'(bus.last_pc), 64'd0);
      chk("rst_mtvec",      64'(bus.mtvec_o), 64'h100);
      chk("rst_mstatus",    64'(bus.id_csr_data), 64'h1800);
      to_neg();
      rst_n = 1'b1;

      // Write and same-cycle bypass
      to_neg();
      commit(32'h0000_0040, 32'h1111_0001);
      bus.wb_regwr = 1'b1; bus.wb_rd = 5'd5; bus.wb_busw = 32'hDEAD_BEEF;
      bus.id_rs1 = 5'd5;
      #1;
      chk("rs1_bypass", 64'(bus.id_rs1_data), 64'hDEAD_BEEF);
      edge_step(); exp_cnt++;
      to_neg(); idle();
      #1;
      chk("rs1_stored", 64'(bus.id_rs1_data), 64'hDEAD_BEEF);
      chk("cnt_after_first", bus.retire_cnt, exp_cnt);
      chk("last_pc_first",   64'(bus.last_pc), 64'h40);
      chk("last_inst_first", 64'(bus.last_inst), 64'h1111_0001);

      // x0 stays zero
      to_neg();
      commit(32'h0000_0044, 32'h1111_0002);
      bus.wb_regwr = 1'b1; bus.wb_rd = 5'd0; bus.wb_busw = 32'h1234;
      bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd5;
      #1;
      chk("x0_before", 64'(bus.id_rs1_data), 64'd0);
      edge_step(); exp_cnt++;
      to_neg(); idle();
      #1;
      chk("x0_after", 64'(bus.id_rs1_data), 64'd0);
      chk("rs2_x5",   64'(bus.id_rs2_data), 64'hDEAD_BEEF);

      // mstatus write with bypass
      to_neg();
      commit(32'h0000_0048, 32'h1111_0003);
      bus.wb_csrwr = 1'b1; bus.wb_csr_rd = 2'd0; bus.wb_csr_busw = 32'hA5;
      bus.id_csr_rs = 2'd0;
      #1;
      chk("mstatus_bypass", 64'(bus.id_csr_data), 64'hA5);
      edge_step(); exp_cnt++;
      to_neg(); idle();
      #1;
      chk("mstatus_stored", 64'(bus.id_csr_data), 64'hA5);

      // Trap beats csrwr to mepc
      to_neg();
      commit(32'h0000_004C, 32'h1111_0004);
      bus.wb_trap = 1'b1; bus.wb_trap_pc = 32'h8000_0010; bus.wb_trap_cause = 32'd11;
      bus.wb_csrwr = 1'b1; bus.wb_csr_rd = 2'd2; bus.wb_csr_busw = 32'hFFFF;
      bus.id_csr_rs = 2'd2;
      #1;
      chk("mepc_bypass_trap", 64'(bus.mepc_o), 64'h8000_0010);
      chk("csr_bypass_trap",  64'(bus.id_csr_data), 64'h8000_0010);
      edge_step(); exp_cnt++;
      to_neg(); idle();
      bus.id_csr_rs = 2'd3;
      #1;
      chk("mcause_trap", 64'(bus.id_csr_data), 64'd11);
      chk("mepc_trap",   64'(bus.mepc_o), 64'h8000_0010);

      // Trap alongside csrwr to mtvec: both land
      to_neg();
      commit(32'h0000_0050, 32'h1111_0005);
      bus.wb_trap = 1'b1; bus.wb_trap_pc = 32'h8000_0020; bus.wb_trap_cause = 32'd2;
      bus.wb_csrwr = 1'b1; bus.wb_csr_rd = 2'd1; bus.wb_csr_busw = 32'h200;
      #1;
      chk("mtvec_bypass", 64'(bus.mtvec_o), 64'h200);
      edge_step(); exp_cnt++;
      to_neg(); idle();
      #1;
      chk("mtvec_stored", 64'(bus.mtvec_o), 64'h200);
      chk("mepc_second",  64'(bus.mepc_o), 64'h8000_0020);
      chk("mcause_second", 64'(bus.id_csr_data), 64'd2);

      // Gating: no commit, no effect
      to_neg();
      bus.wb_pc = 32'h0000_0999;
      bus.wb_regwr = 1'b1; bus.wb_rd = 5'd5; bus.wb_busw = 32'h0;
      bus.wb_csrwr = 1'b1; bus.wb_csr_rd = 2'd1; bus.wb_csr_busw = 32'h0;
      bus.wb_trap = 1'b1; bus.wb_trap_pc = 32'h0; bus.wb_trap_cause = 32'h0;
      bus.id_rs1 = 5'd5;
      #1;
      chk("gate_no_bypass", 64'(bus.id_rs1_data), 64'hDEAD_BEEF);
      edge_step();
      to_neg(); idle();
      #1;
      chk("gate_rs1",     64'(bus.id_rs1_data), 64'hDEAD_BEEF);
      chk("gate_mtvec",   64'(bus.mtvec_o), 64'h200);
      chk("gate_mepc",    64'(bus.mepc_o), 64'h8000_0020);
      chk("gate_cnt",     bus.retire_cnt, exp_cnt);
      chk("gate_last_pc", 64'(bus.last_pc), 64'h50);

      // Async reset with a write pending
      to_neg();
      commit(32'h0000_0060, 32'h1111_0006);
      bus.wb_regwr = 1'b1; bus.wb_rd = 5'd9; bus.wb_busw = 32'h77;
      bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd9; bus.id_csr_rs = 2'd0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cnt",     bus.retire_cnt, 64'd0);
      chk("arst_last_pc", 64'(bus.last_pc), 64'd0);
      chk("arst_rs1",     64'(bus.id_rs1_data), 64'd0);
      chk("arst_mstatus", 64'(bus.id_csr_data), 64'h1800);
      chk("arst_mtvec",   64'(bus.mtvec_o), 64'h100);
      edge_step();
      to_neg(); idle();
      rst_n = 1'b1;
      exp_cnt = 64'd0;
      to_neg();
      #1;
      chk("arst_x9", 64'(bus.id_rs2_data), 64'd0);
      chk("arst_cnt_after", bus.retire_cnt, exp_cnt);

      // Halt sequence
      for (int i = 0; i < 3; i++) begin
         to_neg();
         commit(32'h0000_0010 + 32'(4 * i), 32'h2222_0000 + 32'(i));
         edge_step(); exp_cnt++;
      end
      to_neg();
      commit(32'h0000_001C, 32'h0010_0073);
      bus.wb_halt = 1'b1;
      bus.wb_regwr = 1'b1; bus.wb_rd = 5'd6; bus.wb_busw = 32'h66;
      #1;
      chk("halt_not_yet", 64'(bus.halted), 64'd0);
      edge_step(); exp_cnt++;
      to_neg(); idle();
      commit(32'h0000_0020, 32'h3333_0000);
      bus.wb_regwr = 1'b1; bus.wb_rd = 5'd7; bus.wb_busw = 32'h99;
      bus.id_rs1 = 5'd7; bus.id_rs2 = 5'd6;
      #1;
      chk("halted_no_bypass", 64'(bus.id_rs1_data), 64'd0);
      edge_step();
      to_neg(); idle();
      #1;
      chk("halt_cnt",       bus.retire_cnt, exp_cnt);
      chk("halt_flag",      64'(bus.halted), 64'd1);
      chk("halt_x7",        64'(bus.id_rs1_data), 64'd0);
      chk("halt_own_write", 64'(bus.id_rs2_data), 64'h66);
      chk("halt_last_pc",   64'(bus.last_pc), 64'h1C);
      chk("halt_last_inst", 64'(bus.last_inst), 64'h0010_0073);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
